// File: rtl/reduction_vector_packer.sv
// ============================================================================
//  Module      : reduction_vector_packer
//  Description : Collects scalar elements from an upstream valid/ready stream
//                into a 16-lane vector for the downstream reduction stage.
//                A vector closes when lane 15 is written or elem_last is seen.
//                The vector is then held until the downstream handshake.
//                Optional macro REDUCTION_PACKER_PAD_EN: pad unwritten lanes
//                of a short vector with the identity of the reduction type.
//                Without the macro, unwritten lanes are padded with zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduction_vector_packer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  elem_in,
    input  logic                   elem_valid,
    output logic                   elem_ready,
    input  logic                   elem_last,
    input  logic [2:0]             reduction_type,
    output logic [16*DATA_WIDTH-1:0] vec_out,
    output logic                   vec_valid,
    input  logic                   vec_ready,
    output logic [4:0]             vec_count,
    output logic [2:0]             type_out
);

    localparam int C_LANES = 16;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              lane_idx_q, lane_idx_d;
    logic [DATA_WIDTH-1:0]   lane_q [C_LANES];
    logic [DATA_WIDTH-1:0]   lane_d [C_LANES];
    logic                    vec_valid_q, vec_valid_d;
    logic [4:0]              vec_count_q, vec_count_d;
    logic [2:0]              type_q, type_d;
    logic [DATA_WIDTH-1:0]   pad_w;
    logic                    accept_w;
    logic                    complete_w;

    assign accept_w   = (state_q == FILL) && elem_valid;
    assign complete_w = accept_w && ((lane_idx_q == 4'd15) || elem_last);

`ifdef REDUCTION_PACKER_PAD_EN
    logic [2:0] pad_type_w;

    // Identity of the vector's operation; lane 0 completing uses the live type.
    always_comb begin
        pad_type_w = (lane_idx_q == 4'd0) ? reduction_type : type_q;
        pad_w      = (pad_type_w == 3'd2) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    end
`else
    assign pad_w = {DATA_WIDTH{1'b0}};
`endif

    // Next-state: element capture in FILL, vector release on handshake in HOLD.
    always_comb begin
        state_d     = state_q;
        lane_idx_d  = lane_idx_q;
        vec_valid_d = vec_valid_q;
        vec_count_d = vec_count_q;
        type_d      = type_q;
        for (int i = 0; i < C_LANES; i++) begin
            lane_d[i] = lane_q[i];
        end

        case (state_q)
            FILL: begin
                if (accept_w) begin
                    lane_d[lane_idx_q] = elem_in;
                    lane_idx_d         = lane_idx_q + 4'd1;
                    if (lane_idx_q == 4'd0) begin
                        type_d = reduction_type;
                    end
                    if (complete_w) begin
                        state_d     = HOLD;
                        vec_valid_d = 1'b1;
                        vec_count_d = {1'b0, lane_idx_q} + 5'd1;
                        // Lanes beyond the last real element carry the pad value.
                        for (int i = 0; i < C_LANES; i++) begin
                            if (4'(i) > lane_idx_q) begin
                                lane_d[i] = pad_w;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (vec_ready) begin
                    state_d     = FILL;
                    vec_valid_d = 1'b0;
                    lane_idx_d  = 4'd0;
                    for (int i = 0; i < C_LANES; i++) begin
                        lane_d[i] = {DATA_WIDTH{1'b0}};
                    end
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, control and lane registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            lane_idx_q  <= 4'd0;
            vec_valid_q <= 1'b0;
            vec_count_q <= 5'd0;
            type_q      <= 3'd0;
            for (int i = 0; i < C_LANES; i++) begin
                lane_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            lane_idx_q  <= lane_idx_d;
            vec_valid_q <= vec_valid_d;
            vec_count_q <= vec_count_d;
            type_q      <= type_d;
            for (int i = 0; i < C_LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    generate
        for (genvar g = 0; g < C_LANES; g++) begin : g_lane
            assign vec_out[g*DATA_WIDTH +: DATA_WIDTH] = lane_q[g];
        end
    endgenerate

    assign elem_ready = (state_q == FILL);
    assign vec_valid  = vec_valid_q;
    assign vec_count  = vec_count_q;
    assign type_out   = type_q;

endmodule

`default_nettype wire

// File: tb/tb_reduction_vector_packer.sv
// ============================================================================
//  Module      : tb_reduction_vector_packer
//  Description : Directed self-checking bench for reduction_vector_packer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reduction_vector_packer;

    localparam int DW = 16;

    logic            clk;
    logic            rst_n;
    logic [DW-1:0]   elem_in;
    logic            elem_valid;
    logic            elem_ready;
    logic            elem_last;
    logic [2:0]      reduction_type;
    logic [16*DW-1:0] vec_out;
    logic            vec_valid;
    logic            vec_ready;
    logic [4:0]      vec_count;
    logic [2:0]      type_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [16*DW-1:0] exp_vec;

    reduction_vector_packer #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .elem_in        (elem_in),
        .elem_valid     (elem_valid),
        .elem_ready     (elem_ready),
        .elem_last      (elem_last),
        .reduction_type (reduction_type),
        .vec_out        (vec_out),
        .vec_valid      (vec_valid),
        .vec_ready      (vec_ready),
        .vec_count      (vec_count),
        .type_out       (type_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pad_of(input logic [2:0] t);
`ifdef REDUCTION_PACKER_PAD_EN
        return (t == 3'd2) ? 16'hFFFF : 16'h0000;
`else
        return (t == 3'd2) ? 16'h0000 : 16'h0000;
`endif
    endfunction

    // One element offered for exactly one rising edge.
    task automatic push(input logic [DW-1:0] d, input logic last, input logic [2:0] t);
        @(negedge clk);
        elem_in        = d;
        elem_last      = last;
        reduction_type = t;
        elem_valid     = 1'b1;
        @(posedge clk);
        #1;
        elem_valid = 1'b0;
        elem_last  = 1'b0;
    endtask

    // Handshake edge with vec_ready already high: vector released.
    task automatic finish_vec(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_clr"}, 256'(vec_valid), 256'd0);
        check({tag, "_ready_set"}, 256'(elem_ready), 256'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        elem_in        = '0;
        elem_valid     = 1'b0;
        elem_last      = 1'b0;
        reduction_type = 3'd0;
        vec_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 256'(vec_valid), 256'd0);
        check("rst_count", 256'(vec_count), 256'd0);
        check("rst_type",  256'(type_out),  256'd0);
        check("rst_vec",   256'(vec_out),   256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 256'(elem_ready), 256'd1);

        // Full vector 1..16, type sum.
        for (int i = 0; i < 16; i++) begin
            push(DW'(i + 1), 1'b0, 3'd0);
            if (i == 14) check("full_latency", 256'(vec_valid), 256'd0);
        end
        for (int i = 0; i < 16; i++) exp_vec[i*DW +: DW] = DW'(i + 1);
        check("full_valid", 256'(vec_valid),  256'd1);
        check("full_ready", 256'(elem_ready), 256'd0);
        check("full_vec",   256'(vec_out),    256'(exp_vec));
        check("full_count", 256'(vec_count),  256'd16);
        check("full_type",  256'(type_out),   256'd0);
        finish_vec("full");

        // Short vector 5,9,2 with elem_last, type min; downstream stalled.
        vec_ready = 1'b0;
        push(16'd5, 1'b0, 3'd2);
        push(16'd9, 1'b0, 3'd2);
        push(16'd2, 1'b1, 3'd2);
        for (int i = 0; i < 16; i++) exp_vec[i*DW +: DW] = pad_of(3'd2);
        exp_vec[0*DW +: DW] = 16'd5;
        exp_vec[1*DW +: DW] = 16'd9;
        exp_vec[2*DW +: DW] = 16'd2;
        check("short_valid", 256'(vec_valid), 256'd1);
        check("short_vec",   256'(vec_out),   256'(exp_vec));
        check("short_count", 256'(vec_count), 256'd3);
        check("short_type",  256'(type_out),  256'd2);

        // Stall ten cycles with upstream pushing and elem_last asserted.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            elem_in        = 16'hAAAA;
            elem_valid     = 1'b1;
            elem_last      = 1'b1;
            reduction_type = 3'd1;
            @(posedge clk);
            #1;
            check("stall_ready", 256'(elem_ready), 256'd0);
            check("stall_valid", 256'(vec_valid),  256'd1);
            check("stall_vec",   256'(vec_out),    256'(exp_vec));
            check("stall_count", 256'(vec_count),  256'd3);
        end
        @(negedge clk);
        elem_last = 1'b0;
        vec_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_valid", 256'(vec_valid),  256'd0);
        check("stall_release_ready", 256'(elem_ready), 256'd1);
        // 0xAAAA (type max) accepted at this edge into lane 0.
        @(posedge clk);
        #1;
        elem_valid = 1'b0;
        // Type change to mean mid-vector is ignored.
        push(16'h0003, 1'b1, 3'd3);
        for (int i = 0; i < 16; i++) exp_vec[i*DW +: DW] = pad_of(3'd1);
        exp_vec[0*DW +: DW] = 16'hAAAA;
        exp_vec[1*DW +: DW] = 16'h0003;
        check("type_valid", 256'(vec_valid), 256'd1);
        check("type_vec",   256'(vec_out),   256'(exp_vec));
        check("type_count", 256'(vec_count), 256'd2);
        check("type_out",   256'(type_out),  256'd1);
        finish_vec("type");

        // elem_last on lane 15 equals a full vector.
        for (int i = 0; i < 16; i++) push(DW'(16'h0200 + i), (i == 15), 3'd2);
        for (int i = 0; i < 16; i++) exp_vec[i*DW +: DW] = DW'(16'h0200 + i);
        check("last15_count", 256'(vec_count), 256'd16);
        check("last15_vec",   256'(vec_out),   256'(exp_vec));
        finish_vec("last15");

        // Reset after seven elements discards the partial vector.
        for (int i = 0; i < 7; i++) push(DW'(16'h0050 + i), 1'b0, 3'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 256'(vec_valid), 256'd0);
        check("midrst_vec",   256'(vec_out),   256'd0);
        check("midrst_type",  256'(type_out),  256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(DW'(16'h0100 + i), 1'b0, 3'd0);
            if (i == 14) check("midrst_no_early", 256'(vec_valid), 256'd0);
        end
        for (int i = 0; i < 16; i++) exp_vec[i*DW +: DW] = DW'(16'h0100 + i);
        check("post_valid", 256'(vec_valid), 256'd1);
        check("post_vec",   256'(vec_out),   256'(exp_vec));
        check("post_count", 256'(vec_count), 256'd16);
        finish_vec("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reduction_vector_packer.md
REDUCTION_VECTOR_PACKER -- requirements
Module: reduction_vector_packer

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 16, width of one element (must match the 16-lane reduction stage it feeds).
REQ-002 SHALL have port: clk  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: elem_in  input  DATA_WIDTH  scalar element from upstream stream.
REQ-005 SHALL have port: elem_valid  input  1  elem_in/elem_last/reduction_type valid.
REQ-006 SHALL have port: elem_ready  output  1  packer accepts element this cycle.
REQ-007 SHALL have port: elem_last  input  1  element closes the current vector early.
REQ-008 SHALL have port: reduction_type  input  3  operation code (0 sum, 1 max, 2 min, 3 mean, other pass-through).
REQ-009 SHALL have port: vec_out  output  16*DATA_WIDTH  packed vector; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port: vec_valid  output  1  vec_out/vec_count/type_out valid.
REQ-011 SHALL have port: vec_ready  input  1  downstream reduction stage accepts vector.
REQ-012 SHALL have port: vec_count  output  5  number of real (non-pad) lanes, 1..16.
REQ-013 SHALL have port: type_out  output  3  reduction_type latched with the vector.

Function
REQ-014 SHALL implement two states: FILL (collecting) and HOLD (presenting vector).
REQ-015 SHALL drive elem_ready = 1 in FILL, 0 in HOLD; no skid buffer.
REQ-016 SHALL accept an element when elem_valid && elem_ready, writing it to lane[lane_idx] and incrementing the 4-bit lane_idx.
REQ-017 SHALL latch reduction_type into type_out only on acceptance of lane 0; later type changes within a vector are ignored.
REQ-018 SHALL move FILL->HOLD on the accept cycle where lane_idx==15 or elem_last==1; vec_valid rises the following cycle (1-cycle latency from completing element).
REQ-019 SHALL set vec_count = lane_idx+1 of the completing element (16 when full; elem_last on lane 15 behaves identically to full).
REQ-020 SHALL hold vec_out, vec_count, type_out, vec_valid stable in HOLD until vec_valid && vec_ready.
REQ-021 SHALL on the handshake cycle return to FILL, clear vec_valid, reset lane_idx to 0, and reinitialise all lanes to the fill value of REQ-027/028; elem_ready is 1 the next cycle.
REQ-022 SHALL ignore elem_valid and elem_last while in HOLD.
REQ-023 SHALL never emit an empty vector; vec_count==0 is unreachable.
REQ-024 SHALL hold partial contents and lane_idx indefinitely in FILL when elem_valid is low (no timeout).

Reset
REQ-025 SHALL on rst_n low, asynchronously: state FILL, lane_idx 0, all lanes 0, vec_valid 0, vec_count 0, type_out 0, elem_ready 1 after release.
REQ-026 SHALL discard any partial or held vector on reset mid-operation; no vector is emitted for it.

Configuration
REQ-027 SHALL, with REDUCTION_PACKER_PAD_EN defined, fill unwritten lanes of a short vector with the identity of type_out: 0 for sum/mean/pass-through, 0 for max (unsigned), all-ones for min (unsigned).
REQ-028 SHALL, without REDUCTION_PACKER_PAD_EN, fill unwritten lanes with 0 for every type; vec_count is still reported.

Verification
REQ-029 SHALL cover: 16 elements 1..16 back-to-back, type 0, vec_ready=1 -> vec_valid one cycle after 16th, lane i = i+1, vec_count=16, type_out=0.
REQ-030 SHALL cover: 3 elements 5,9,2 with elem_last on the third, type 2, PAD_EN defined -> lanes 0..2 = 5,9,2, lanes 3..15 = 0xFFFF, vec_count=3, type_out=2.
REQ-031 SHALL cover: same as REQ-030 without PAD_EN -> lanes 3..15 = 0x0000, vec_count=3.
REQ-032 SHALL cover: vec_ready held 0 for 10 cycles with elem_valid=1 -> elem_ready=0, vec_out unchanged; after vec_ready=1, next element lands in lane 0.
REQ-033 SHALL cover: reduction_type changes 1->3 after lane 0 accepted -> type_out=1 for that vector.
REQ-034 SHALL cover: rst_n pulsed low after 7 elements accepted -> vec_valid=0, following 16 elements produce one vector with lane 0 = first post-reset element.
